// File: rtl/loader_pkg.sv
// Purpose: shared state encoding and word geometry for the instruction-memory loader.
// Latency: none; this file holds only type and constant definitions.
// Backpressure: not applicable.
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// Purpose: packs incoming bytes little-endian into a 32-bit word with a 2-bit slot index.
// Latency: a byte loaded at edge k is visible in word_out from cycle k+1.
// Backpressure: none; the caller decides when to pulse load_en.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_clk,
  input  logic        clear,
  input  logic        load_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        last
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;

  // Insert the byte into the slot chosen by the index, then advance the index.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear) begin
      idx_d  = 2'd0;
      word_d = 32'd0;
    end else if (load_en) begin
      case (idx_q)
        2'd0:    word_d[7:0]   = byte_in;
        2'd1:    word_d[15:8]  = byte_in;
        2'd2:    word_d[23:16] = byte_in;
        default: word_d[31:24] = byte_in;
      endcase
      // Wraps from 3 back to 0 so the next word starts at byte lane 0.
      idx_d = idx_q + 2'd1;
    end
  end

  // Index and word register; reset throws away any partially packed word.
  always_ff @(posedge clk) begin
    if (rst_clk) begin
      idx_q  <= 2'd0;
      word_q <= 32'd0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_out = word_q;
  assign last     = (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Purpose: streams bytes into 32-bit words and writes them to consecutive instruction-RAM addresses, stalling the CPU meanwhile.
// Latency: last byte of a word accepted at edge k gives mem_we in cycle k+1; at least 5 cycles per word.
// Backpressure: in_ready is high only while collecting bytes; a low in_valid simply waits, with no timeout.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_clk,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_stall,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_cnt
);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic                pk_clear;
  logic                pk_load;
  logic                pk_last;
  logic [31:0]         pk_word;

  byte_packer u_packer (
    .clk      (clk),
    .rst_clk  (rst_clk),
    .clear    (pk_clear),
    .load_en  (pk_load),
    .byte_in  (in_byte),
    .word_out (pk_word),
    .last     (pk_last)
  );

  // Next-state logic: capture length on start, collect bytes, write one word, repeat until the count is reached.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    pk_clear = 1'b0;
    pk_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = len_words;
          cnt_d    = '0;
          pk_clear = 1'b1;
          // A zero-length request completes immediately without touching memory.
          state_d  = (len_words == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (in_valid) begin
          pk_load = 1'b1;
          if (pk_last) begin
            // Register the target address now so mem_addr is a flop output during WRITE.
            addr_d  = BASE_ADDR + cnt_q[ADDR_W-1:0];
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        cnt_d   = cnt_q + (ADDR_W+1)'(1);
        state_d = (cnt_d == len_q) ? DONE : RECV;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, captured length, word counter and write address registers.
  always_ff @(posedge clk) begin
    if (rst_clk) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // All outputs come from state decode or registers; no input reaches an output combinationally.
  assign in_ready  = (state_q == RECV);
  assign mem_we    = (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign cpu_stall = busy;
  assign mem_addr  = addr_q;
  assign mem_wdata = pk_word;
  assign word_cnt  = cnt_q;

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Writer-side counterpart to the PC/instruction-fetch path. Receives a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instruction words, and writes them into the instruction memory at consecutive word addresses. While it runs, it holds the CPU fetch stage in stall. The block sits between the host/boot byte source and the instruction RAM write port, beside the PC/instruction-display top.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory word-address width.
- `BASE_ADDR`, 0: first word address written; `ADDR_W` bits.

Ports (single clock; reset is synchronous and active-high):
- `clk`, input, 1: system clock, rising edge.
- `rst_clk`, input, 1: synchronous active-high reset.
- `start`, input, 1: one-cycle request to begin a load; sampled only in IDLE.
- `len_words`, input, `ADDR_W+1`: number of words to load; captured on an accepted `start`.
- `in_valid`, input, 1: byte source has data.
- `in_byte`, input, 8: data byte.
- `in_ready`, output, 1: loader accepts a byte this cycle.
- `mem_we`, output, 1: instruction-RAM write enable.
- `mem_addr`, output, `ADDR_W`: word address.
- `mem_wdata`, output, 32: instruction word.
- `cpu_stall`, output, 1: holds PC/fetch.
- `busy`, output, 1: loader not in IDLE.
- `done`, output, 1: one-cycle completion pulse.
- `word_cnt`, output, `ADDR_W+1`: words written in the current or last load.

## Operation
- The FSM has four states: IDLE, RECV, WRITE, DONE.
- IDLE:
  - `start` with `len_words != 0` captures the length, clears `word_cnt` and the byte index, and goes to RECV.
  - `start` with `len_words == 0` goes to DONE; no write occurs.
- RECV:
  - `in_ready` = 1.
  - A byte is accepted when `in_valid && in_ready`. Byte index 0..3 maps to word bits [7:0], [15:8], [23:16], [31:24].
  - Accepting byte index 3 moves the FSM to WRITE.
- WRITE:
  - `in_ready` = 0 and `mem_we` = 1 for exactly this one cycle.
  - `mem_addr` = (`BASE_ADDR` + `word_cnt`) mod 2^`ADDR_W`; `mem_wdata` = the packed word.
  - `word_cnt` increments at the end of the cycle.
  - Next state is DONE if the incremented count equals the captured length, otherwise RECV.
- DONE: `done` = 1 for one cycle, then the FSM returns to IDLE. `word_cnt` holds its value until the next accepted `start`.
- `busy` = `cpu_stall` = (state != IDLE).
- `start` outside IDLE is ignored.
- `in_valid` low in RECV stalls indefinitely, with no timeout.
- The address wraps modulo 2^`ADDR_W`; `len_words` up to 2^`ADDR_W` is legal.
- `mem_addr`/`mem_wdata` are don't-care when `mem_we` = 0. The implementation drives them from registers.

## Timing
- Reset, applied at any time including mid-load:
  - The next state is IDLE.
  - Outputs become `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_stall`=0, `busy`=0, `done`=0, `word_cnt`=0.
  - A partially packed word is discarded and never written.
- `start` sampled high at edge n: `busy`/`cpu_stall`/`in_ready` are high from cycle n+1.
- Last byte of a word accepted at edge k: `mem_we` is high in cycle k+1, and RECV (or DONE) begins at k+2.
- Minimum throughput is 5 cycles per word.
- Load completion: `done` is high in the cycle after the final WRITE, and `busy` drops the cycle after that.
- All outputs are registered or decoded from state; there are no combinational input-to-output paths except none. `in_ready` depends on state only.

## Structure
- Shared package `loader_pkg`: state encoding (IDLE=0, RECV=1, WRITE=2, DONE=3) and `BYTES_PER_WORD`=4.
- Sub-module `byte_packer`: a 2-bit index plus a 32-bit shift/insert register, with `clear`, `load_en`, `byte_in`, `word_out` and `last` (index==3).
- The top FSM, counter and address adder stay in `instr_mem_loader`.

## Test plan
- Reset, then `start`, `len_words`=2, bytes 0x13,0x00,0x10,0x20 then 0x01,0x02,0x03,0x04 streamed with continuous valid:
  - writes 0x20100013 to addr 0 and 0x04030201 to addr 1;
  - `done` pulses once; `word_cnt`=2; `cpu_stall` is high from the cycle after `start` to the cycle after `done`.
- `in_valid` toggled 1-0-0-1-0-1-1 during one word: exactly four bytes are accepted, `mem_we` fires once, and the data is correct.
- `BASE_ADDR`=254, `ADDR_W`=8, `len_words`=3: writes go to addresses 254, 255, 0.
- `start` with `len_words`=0: `done` pulses 1 cycle later, `mem_we` never asserts, and `word_cnt`=0.
- `rst_clk` after 2 bytes of word 1 in a 2-word load: no further `mem_we`; all outputs are at their reset values the cycle after reset; a fresh load then succeeds.
- Second `start` pulsed mid-load is ignored: the captured length is unchanged, and exactly the original number of writes occur.
